// File: rtl/rforest_seq_ctrl_if.sv
// rforest_seq_ctrl_if: feature stream and class result handshakes.
// Producer side uses master; the sequencer uses slave.
interface rforest_seq_ctrl_if #(
    parameter int FEAT_W = 10,
    parameter int CLS_W  = 5
);
    logic              feat_valid;
    logic              feat_ready;
    logic [FEAT_W-1:0] feat_data;
    logic              feat_last;
    logic              res_valid;
    logic              res_ready;
    logic [CLS_W-1:0]  res_class;

    modport master (
        output feat_valid,
        output feat_data,
        output feat_last,
        output res_ready,
        input  feat_ready,
        input  res_valid,
        input  res_class
    );

    modport slave (
        input  feat_valid,
        input  feat_data,
        input  feat_last,
        input  res_ready,
        output feat_ready,
        output res_valid,
        output res_class
    );
endinterface

// File: rtl/rforest_seq_ctrl.sv
// rforest_seq_ctrl: serial feature loader, settle timer and result port
// for the RForest classifier. Optional counters: RFOREST_PERF_CNT_EN.
module rforest_seq_ctrl #(
    parameter int NUM_FEAT   = 52,
    parameter int FEAT_W     = 10,
    parameter int CLS_W      = 5,
    parameter int SETTLE_CYC = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    rforest_seq_ctrl_if.slave          io_s,
    output logic [NUM_FEAT*FEAT_W-1:0] o_feat_bus,
    input  logic [CLS_W-1:0]           i_cls_in,
    output logic                       o_busy,
    output logic                       o_err_frame
`ifdef RFOREST_PERF_CNT_EN
    ,
    output logic [15:0]                o_vec_count,
    output logic [7:0]                 o_err_count
`endif
);

    localparam int IDX_W = $clog2(NUM_FEAT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEAT - 1);
    localparam logic [3:0] SETTLE_END = 4'(SETTLE_CYC);

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_SETTLE = 2'd1,
        S_OUT    = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [IDX_W-1:0]           r_idx;
    logic [IDX_W-1:0]           w_idx_nxt;
    logic [3:0]                 r_cnt;
    logic [3:0]                 w_cnt_nxt;
    logic [NUM_FEAT*FEAT_W-1:0] r_feat_bus;
    logic                       r_res_valid;
    logic [CLS_W-1:0]           r_res_class;
    logic                       r_err;

    logic w_feat_hs;
    logic w_at_last;
    logic w_wr_en;
    logic w_err_nxt;
    logic w_capture;
    logic w_res_hs;

    assign w_feat_hs = io_s.feat_valid && (r_state == S_LOAD);
    assign w_at_last = (r_idx == LAST_IDX);

    // State, slot index and settle counter registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_LOAD;
            r_idx   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic: framing check, settle timing, result release
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_wr_en     = 1'b0;
        w_err_nxt   = 1'b0;
        w_capture   = 1'b0;
        w_res_hs    = 1'b0;
        unique case (r_state)
            S_LOAD: begin
                if (w_feat_hs) begin
                    w_wr_en = 1'b1;
                    unique case (1'b1)
                        (io_s.feat_last && w_at_last): begin
                            w_state_nxt = S_SETTLE;
                            w_cnt_nxt   = 4'd1;
                        end
                        (!io_s.feat_last && !w_at_last): begin
                            w_idx_nxt = r_idx + 1'b1;
                        end
                        default: begin
                            w_err_nxt = 1'b1;
                            w_idx_nxt = '0;
                        end
                    endcase
                end
            end
            S_SETTLE: begin
                w_cnt_nxt = r_cnt + 4'd1;
                if (r_cnt == SETTLE_END) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_OUT;
                    w_cnt_nxt   = '0;
                end
            end
            S_OUT: begin
                if (io_s.res_ready) begin
                    w_res_hs    = 1'b1;
                    w_state_nxt = S_LOAD;
                    w_idx_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_LOAD;
                w_idx_nxt   = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Feature bank, captured class, result valid and error pulse
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_feat_bus  <= '0;
            r_res_valid <= 1'b0;
            r_res_class <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_feat_bus[int'(r_idx)*FEAT_W +: FEAT_W] <= io_s.feat_data;
            end
            if (w_capture) begin
                r_res_class <= i_cls_in;
                r_res_valid <= 1'b1;
            end else if (w_res_hs) begin
                r_res_valid <= 1'b0;
            end
            r_err <= w_err_nxt;
        end
    end

`ifdef RFOREST_PERF_CNT_EN
    logic [15:0] r_vec_count;
    logic [7:0]  r_err_count;

    // Saturating counts of delivered results and framing errors
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_vec_count <= '0;
            r_err_count <= '0;
        end else begin
            if (w_res_hs && (r_vec_count != 16'hFFFF)) begin
                r_vec_count <= r_vec_count + 16'd1;
            end
            if (r_err && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign o_vec_count = r_vec_count;
    assign o_err_count = r_err_count;
`endif

    assign io_s.feat_ready = (r_state == S_LOAD);
    assign io_s.res_valid  = r_res_valid;
    assign io_s.res_class  = r_res_class;
    assign o_feat_bus      = r_feat_bus;
    assign o_busy          = (r_state != S_LOAD);
    assign o_err_frame     = r_err;

endmodule

// File: tb/tb_rforest_seq_ctrl.sv
// tb_rforest_seq_ctrl: directed vectors against a stub classifier
// cls = slot0[4:0] ^ slot51[4:0].
module tb_rforest_seq_ctrl;

    localparam int NF = 52;
    localparam int FW = 10;
    localparam int CW = 5;

    logic            clk;
    logic            rst_n;
    logic [NF*FW-1:0] feat_bus;
    logic [CW-1:0]   cls_in;
    logic            busy;
    logic            err_frame;
`ifdef RFOREST_PERF_CNT_EN
    logic [15:0]     vec_count;
    logic [7:0]      err_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int n_err   = 0;

    rforest_seq_ctrl_if #(.FEAT_W(FW), .CLS_W(CW)) u_if ();

    rforest_seq_ctrl #(
        .NUM_FEAT  (NF),
        .FEAT_W    (FW),
        .CLS_W     (CW),
        .SETTLE_CYC(2)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .io_s       (u_if),
        .o_feat_bus (feat_bus),
        .i_cls_in   (cls_in),
        .o_busy     (busy),
        .o_err_frame(err_frame)
`ifdef RFOREST_PERF_CNT_EN
        ,
        .o_vec_count(vec_count),
        .o_err_count(err_count)
`endif
    );

    assign cls_in = feat_bus[4:0] ^ feat_bus[51*FW +: 5];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (err_frame === 1'b1) n_err++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [FW-1:0] pat(input int kind, input int i);
        case (kind)
            0:       pat = FW'(i + 1);
            1:       pat = FW'(7);
            2:       pat = FW'(2 * i + 3);
            default: pat = FW'(i * 5);
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [FW-1:0] d, input logic l);
        bit ok;
        ok = 1'b0;
        u_if.feat_valid = 1'b1;
        u_if.feat_data  = d;
        u_if.feat_last  = l;
        for (int c = 0; c < 100 && !ok; c++) begin
            ok = u_if.feat_ready;
            step();
        end
        u_if.feat_valid = 1'b0;
        u_if.feat_last  = 1'b0;
        if (!ok) chk("feat_hs_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_vec(input int kind);
        for (int i = 0; i < NF; i++) send_word(pat(kind, i), i == NF - 1);
    endtask

    task automatic wait_res();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 40 && !ok; c++) begin
            step();
            ok = u_if.res_valid;
        end
        if (!ok) chk("res_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_vec(input int kind, input logic [CW-1:0] exp,
                           input string tag);
        send_vec(kind);
        wait_res();
        chk(tag, u_if.res_class, exp);
        step();
        chk({tag, "_rv_clr"}, u_if.res_valid, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n           = 1'b0;
        u_if.feat_valid = 1'b0;
        u_if.feat_data  = '0;
        u_if.feat_last  = 1'b0;
        u_if.res_ready  = 1'b1;
        step();
        step();
        rst_n = 1'b1;

        chk("rst_feat_ready", u_if.feat_ready, 1'b1);
        chk("rst_res_valid", u_if.res_valid, 1'b0);
        chk("rst_res_class", u_if.res_class, 5'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err_frame, 1'b0);
        chk("rst_bus_zero", |feat_bus, 1'b0);

        // Test 1: legal vector and latency
        send_vec(0);
        chk("t1_busy", busy, 1'b1);
        chk("t1_ready_settle", u_if.feat_ready, 1'b0);
        chk("t1_slot10", feat_bus[10*FW +: FW], 10'd11);
        chk("t1_slot51", feat_bus[51*FW +: FW], 10'd52);
        step();
        chk("t1_rv_k1", u_if.res_valid, 1'b0);
        step();
        chk("t1_rv_k2", u_if.res_valid, 1'b1);
        chk("t1_class", u_if.res_class, 5'h15);
        step();
        chk("t1_rv_after_hs", u_if.res_valid, 1'b0);
        chk("t1_ready_after_hs", u_if.feat_ready, 1'b1);
        chk("t1_class_hold", u_if.res_class, 5'h15);
        chk("t1_no_err", n_err, 0);

        // Test 2: early feat_last on the 10th word
        for (int i = 0; i < 9; i++) send_word(10'h3AA, 1'b0);
        send_word(10'h3AA, 1'b1);
        chk("t2_err_pulse", err_frame, 1'b1);
        chk("t2_slot9_written", feat_bus[9*FW +: FW], 10'h3AA);
        step();
        chk("t2_err_clear", err_frame, 1'b0);
        chk("t2_no_result", u_if.res_valid, 1'b0);
        chk("t2_ready", u_if.feat_ready, 1'b1);
        run_vec(1, 5'h00, "t2_class");
        chk("t2_err_count", n_err, 1);

        // Test 3: 52 words with no feat_last
        for (int i = 0; i < NF; i++) send_word(10'h155, 1'b0);
        chk("t3_err_pulse", err_frame, 1'b1);
        chk("t3_busy", busy, 1'b0);
        step();
        chk("t3_no_result", u_if.res_valid, 1'b0);
        run_vec(2, 5'h0A, "t3_class");
        chk("t3_err_count", n_err, 2);

        // Test 4: result back-pressure
        u_if.res_ready = 1'b0;
        send_vec(3);
        wait_res();
        chk("t4_class", u_if.res_class, 5'h1F);
        for (int c = 0; c < 20; c++) begin
            u_if.feat_valid = c[0];
            u_if.feat_data  = 10'h2F0;
            step();
            chk("t4_rv_hold", u_if.res_valid, 1'b1);
            chk("t4_class_hold", u_if.res_class, 5'h1F);
            chk("t4_ready_low", u_if.feat_ready, 1'b0);
        end
        u_if.feat_valid = 1'b0;
        chk("t4_slot0_kept", feat_bus[FW-1:0], 10'd0);
        chk("t4_slot51_kept", feat_bus[51*FW +: FW], 10'd255);
        u_if.res_ready = 1'b1;
        step();
        chk("t4_rv_clr", u_if.res_valid, 1'b0);
        chk("t4_ready_back", u_if.feat_ready, 1'b1);

        // Test 5: reset during SETTLE and during LOAD at idx 30
        send_vec(0);
        chk("t5_in_settle", busy, 1'b1);
        do_reset();
        chk("t5a_busy", busy, 1'b0);
        chk("t5a_rv", u_if.res_valid, 1'b0);
        chk("t5a_class", u_if.res_class, 5'h00);
        chk("t5a_bus_zero", |feat_bus, 1'b0);
        chk("t5a_ready", u_if.feat_ready, 1'b1);
        step();
        step();
        chk("t5a_no_result", u_if.res_valid, 1'b0);
        for (int i = 0; i < 30; i++) send_word(10'h3FF, 1'b0);
        do_reset();
        chk("t5b_bus_zero", |feat_bus, 1'b0);
        chk("t5b_err", err_frame, 1'b0);
        run_vec(0, 5'h15, "t5b_class");

`ifdef RFOREST_PERF_CNT_EN
        // Optional counters
        do_reset();
        chk("pc_rst_vec", vec_count, 16'd0);
        chk("pc_rst_err", err_count, 8'd0);
        run_vec(0, 5'h15, "pc_v1");
        send_word(10'h1, 1'b1);
        run_vec(1, 5'h00, "pc_v2");
        for (int i = 0; i < 3; i++) send_word(10'h2, i == 2);
        run_vec(2, 5'h0A, "pc_v3");
        chk("pc_vec3", vec_count, 16'd3);
        chk("pc_err2", err_count, 8'd2);
        force dut.r_vec_count = 16'hFFFF;
        step();
        release dut.r_vec_count;
        run_vec(0, 5'h15, "pc_v4");
        chk("pc_vec_sat", vec_count, 16'hFFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
